// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM for the 16-bit ALU datapath: fetch over req/ack, decode,
// drive ALU control fields, latch compare flags, write back, and update the PC.
module alu_seq_ctrl #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  rf_raddr1,
  output logic [2:0]  rf_raddr2,
  input  logic [15:0] rf_rdata2,
  output logic [3:0]  alu_opcode,
  output logic [1:0]  alu_ot,
  output logic [3:0]  alu_b2opcode,
  input  logic [2:0]  alu_addr_out,
  input  logic        alu_eq,
  input  logic        alu_gt,
  input  logic        alu_lt,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] pc,
  output logic [2:0]  flags,
  output logic        busy,
  output logic        halted,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERROR
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(FETCH_TIMEOUT - 1);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_BGT  = 4'b0100;
  localparam logic [3:0] OP_BLT  = 4'b0101;

  state_t      state, state_nxt;
  logic [15:0] pc_r, pc_nxt;
  logic [15:0] ir, ir_nxt;
  logic [2:0]  flags_r, flags_nxt;
  logic [15:0] tcnt, tcnt_nxt;
  logic [1:0]  ot_r;
  logic [3:0]  op_r;
  logic [3:0]  b2_r;

  logic [1:0] ir_ot;
  logic [3:0] ir_op;
  logic [2:0] ir_rd;
  logic [2:0] ir_rs;
  logic [3:0] ir_am;

  assign ir_ot = ir[15:14];
  assign ir_op = ir[13:10];
  assign ir_rd = ir[9:7];
  assign ir_rs = ir[6:4];
  assign ir_am = ir[3:0];

  function automatic logic [15:0] pc_inc(input logic [15:0] p);
    return p + 16'd1;
  endfunction

  // Branch target select; flags are {eq,gt,lt} as held before the branch.
  function automatic logic [15:0] br_target(input logic taken, input logic [15:0] p,
                                            input logic [15:0] tgt);
    return taken ? tgt : pc_inc(p);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_r    <= RESET_PC;
      ir      <= '0;
      flags_r <= '0;
      tcnt    <= '0;
      ot_r    <= '0;
      op_r    <= '0;
      b2_r    <= '0;
    end else begin
      state   <= state_nxt;
      pc_r    <= pc_nxt;
      ir      <= ir_nxt;
      flags_r <= flags_nxt;
      tcnt    <= tcnt_nxt;
      if (state == S_DECODE) begin
        ot_r <= ir_ot;
        op_r <= ir_op;
        b2_r <= ir_am;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_r;
    ir_nxt    = ir;
    flags_nxt = flags_r;
    tcnt_nxt  = tcnt;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          tcnt_nxt  = '0;
          state_nxt = S_DECODE;
        end else if (tcnt == TO_LAST) begin
          tcnt_nxt  = '0;
          state_nxt = S_ERROR;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (ir_ot == 2'b11) begin
          state_nxt = S_FETCH;
          case (ir_op)
            OP_NOP:  pc_nxt = pc_inc(pc_r);
            OP_HALT: state_nxt = S_HALT;
            OP_JMP:  pc_nxt = rf_rdata2;
            OP_BEQ:  pc_nxt = br_target(flags_r[2], pc_r, rf_rdata2);
            OP_BGT:  pc_nxt = br_target(flags_r[1], pc_r, rf_rdata2);
            OP_BLT:  pc_nxt = br_target(flags_r[0], pc_r, rf_rdata2);
            default: state_nxt = S_ERROR;
          endcase
        end else begin
          if (ir_ot == 2'b10) flags_nxt = {alu_eq, alu_gt, alu_lt};
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        pc_nxt    = pc_inc(pc_r);
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic in_inst;
  assign in_inst = (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);

  assign imem_req     = (state == S_FETCH);
  assign imem_addr    = imem_req ? pc_r : '0;
  assign rf_raddr1    = in_inst ? ir_rd : '0;
  assign rf_raddr2    = in_inst ? ir_rs : '0;
  assign alu_ot       = ot_r;
  assign alu_opcode   = op_r;
  assign alu_b2opcode = b2_r;
  assign rf_we        = (state == S_WB);
  assign rf_waddr     = rf_we ? alu_addr_out : '0;
  assign pc           = pc_r;
  assign flags        = flags_r;
  assign busy         = (state != S_IDLE) && (state != S_HALT) && (state != S_ERROR);
  assign halted       = (state == S_HALT);
  assign error        = (state == S_ERROR);

endmodule
